// File: rtl/swd_pkg.sv
// Shared constants and types for the SWD target: FSM state codes, ACK codes,
// line-reset length and the header check.
package swd_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_HDR   = 4'd1;
  localparam logic [3:0] ST_TRN1  = 4'd2;
  localparam logic [3:0] ST_ACK   = 4'd3;
  localparam logic [3:0] ST_RDATA = 4'd4;
  localparam logic [3:0] ST_RPAR  = 4'd5;
  localparam logic [3:0] ST_TRN2  = 4'd6;
  localparam logic [3:0] ST_WDATA = 4'd7;
  localparam logic [3:0] ST_WPAR  = 4'd8;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam logic [5:0] LINE_RESET_BITS = 6'd50;
  localparam logic [5:0] DATA_BITS       = 6'd32;

  typedef struct packed {
    logic       apndp;
    logic       rnw;
    logic [1:0] addr;
  } swd_req_t;

  // hdr holds APnDP, RnW, A2, A3, parity, stop, park in bits 0..6
  function automatic logic hdr_valid(input logic [6:0] hdr);
    return (hdr[4] == ^hdr[3:0]) && !hdr[5] && hdr[6];
  endfunction

endpackage

// File: rtl/swd_target_if.sv
// Upstream side of the SWD target: decoded request, response and write data.
interface swd_target_if;
  logic        req_valid;
  logic        req_apndp;
  logic        req_rnw;
  logic [1:0]  req_addr;
  logic        resp_valid;
  logic [2:0]  resp_ack;
  logic [31:0] resp_rdata;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_perr;
  logic        line_reset;
  logic        proto_err;

  modport slave (
    output req_valid, req_apndp, req_rnw, req_addr,
    output wr_valid, wr_data, wr_perr, line_reset, proto_err,
    input  resp_valid, resp_ack, resp_rdata
  );

  modport master (
    input  req_valid, req_apndp, req_rnw, req_addr,
    input  wr_valid, wr_data, wr_perr, line_reset, proto_err,
    output resp_valid, resp_ack, resp_rdata
  );
endinterface

// File: rtl/swd_edge_sync.sv
// Synchronises SWCLK/SWDIO into clk and produces a one-clk SWCLK rise strobe.
// Both lines pass through equal-depth chains so the sampled bit lines up with the strobe.
module swd_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_swclk,
  input  logic i_swdio,
  output logic o_rise,
  output logic o_swdio
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dio_sync;
  logic                   r_clk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= '0;
      r_dio_sync <= '0;
      r_clk_prev <= 1'b0;
    end else begin
      r_clk_sync[0] <= i_swclk;
      r_dio_sync[0] <= i_swdio;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_clk_sync[i] <= r_clk_sync[i-1];
        r_dio_sync[i] <= r_dio_sync[i-1];
      end
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise  = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
  assign o_swdio = r_dio_sync[SYNC_STAGES-1];

endmodule

// File: rtl/swd_target.sv
// SWD wire-protocol target: header decode, ACK, read/write data phases, line reset.
// All protocol activity advances only on the synchronised SWCLK rise strobe.
module swd_target
  import swd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swclk_i,
  input  logic        swdio_i,
  output logic        swdio_o,
  output logic        swdio_oe,
  input  logic [1:0]  turnaround,
  swd_target_if.slave bus
);

  // state | meaning
  // IDLE  | wait for start bit    HDR   | 7 header bits    TRN1 | turnaround, then ACK0
  // ACK   | ACK1..2, then branch  RDATA | drive 32 bits    RPAR | drive parity
  // TRN2  | turnaround to host    WDATA | sample 32 bits   WPAR | sample parity

  logic        w_rise;
  logic        w_bit;
  logic [6:0]  w_hdr_next;
  logic        w_tlast;
  logic        w_lr;

  logic [3:0]  r_state;
  logic [5:0]  r_cnt;
  logic [5:0]  r_ones;
  logic [6:0]  r_hdr;
  logic [2:0]  r_ack;
  logic [31:0] r_rdata;
  logic [31:0] r_wshift;
  logic [31:0] r_wr_data;
  swd_req_t    r_req;
  logic        r_swdio_o;
  logic        r_swdio_oe;
  logic        r_req_valid;
  logic        r_wr_valid;
  logic        r_wr_perr;
  logic        r_line_reset;
  logic        r_proto_err;

  swd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_swclk (swclk_i),
    .i_swdio (swdio_i),
    .o_rise  (w_rise),
    .o_swdio (w_bit)
  );

  assign w_hdr_next = {w_bit, r_hdr[6:1]};
  assign w_tlast    = (r_cnt == {4'd0, turnaround});
  // Only bits sampled while the host owns the line count towards a line reset
  assign w_lr       = w_rise & ~r_swdio_oe & w_bit & (r_ones == LINE_RESET_BITS - 6'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ones       <= '0;
      r_hdr        <= '0;
      r_ack        <= '0;
      r_rdata      <= '0;
      r_wshift     <= '0;
      r_wr_data    <= '0;
      r_req        <= '0;
      r_swdio_o    <= 1'b0;
      r_swdio_oe   <= 1'b0;
      r_req_valid  <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_wr_perr    <= 1'b0;
      r_line_reset <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_req_valid  <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_line_reset <= 1'b0;
      r_proto_err  <= 1'b0;
      if (w_rise) begin
        if (!r_swdio_oe) begin
          if (!w_bit)                        r_ones <= '0;
          else if (r_ones != LINE_RESET_BITS) r_ones <= r_ones + 6'd1;
        end
        if (w_lr) begin
          r_line_reset <= 1'b1;
          r_state      <= ST_IDLE;
          r_cnt        <= '0;
        end else begin
          case (r_state)
            // a saturated ones count means the line is still held high after a reset
            ST_IDLE: if (w_bit && r_ones != LINE_RESET_BITS) begin
              r_state <= ST_HDR;
              r_cnt   <= '0;
            end
            ST_HDR: begin
              r_hdr <= w_hdr_next;
              if (r_cnt == 6'd6) begin
                r_cnt <= '0;
                if (hdr_valid(w_hdr_next)) begin
                  r_req_valid <= 1'b1;
                  r_req       <= '{apndp: w_hdr_next[0], rnw: w_hdr_next[1], addr: w_hdr_next[3:2]};
                  r_state     <= ST_TRN1;
                end else begin
                  r_proto_err <= 1'b1;
                  r_state     <= ST_IDLE;
                end
              end else begin
                r_cnt <= r_cnt + 6'd1;
              end
            end
            ST_TRN1: if (w_tlast) begin
              r_swdio_oe <= 1'b1;
              r_cnt      <= 6'd1;
              r_state    <= ST_ACK;
              if (bus.resp_valid) begin
                r_ack     <= bus.resp_ack;
                r_rdata   <= bus.resp_rdata;
                r_swdio_o <= bus.resp_ack[0];
              end else begin
                r_ack     <= ACK_WAIT;
                r_swdio_o <= ACK_WAIT[0];
              end
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
            ST_ACK: if (r_cnt != 6'd3) begin
              r_swdio_o <= r_ack[r_cnt[1:0]];
              r_cnt     <= r_cnt + 6'd1;
            end else if (r_ack == ACK_OK && r_req.rnw) begin
              r_swdio_o <= r_rdata[0];
              r_cnt     <= 6'd1;
              r_state   <= ST_RDATA;
            end else begin
              r_swdio_oe <= 1'b0;
              r_swdio_o  <= 1'b0;
              r_cnt      <= '0;
              r_state    <= (r_ack == ACK_OK) ? ST_TRN2 : ST_IDLE;
            end
            ST_RDATA: if (r_cnt == DATA_BITS) begin
              r_swdio_o <= ^r_rdata;
              r_cnt     <= '0;
              r_state   <= ST_RPAR;
            end else begin
              r_swdio_o <= r_rdata[r_cnt[4:0]];
              r_cnt     <= r_cnt + 6'd1;
            end
            ST_RPAR: begin
              r_swdio_oe <= 1'b0;
              r_swdio_o  <= 1'b0;
              r_state    <= ST_IDLE;
            end
            ST_TRN2: if (w_tlast) begin
              r_cnt   <= '0;
              r_state <= ST_WDATA;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
            ST_WDATA: begin
              r_wshift <= {w_bit, r_wshift[31:1]};
              r_cnt    <= r_cnt + 6'd1;
              if (r_cnt == DATA_BITS - 6'd1) r_state <= ST_WPAR;
            end
            ST_WPAR: begin
              r_wr_valid <= 1'b1;
              r_wr_data  <= r_wshift;
              r_wr_perr  <= w_bit ^ (^r_wshift);
              r_cnt      <= '0;
              r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign swdio_o        = r_swdio_o;
  assign swdio_oe       = r_swdio_oe;
  assign bus.req_valid  = r_req_valid;
  assign bus.req_apndp  = r_req.apndp;
  assign bus.req_rnw    = r_req.rnw;
  assign bus.req_addr   = r_req.addr;
  assign bus.wr_valid   = r_wr_valid;
  assign bus.wr_data    = r_wr_data;
  assign bus.wr_perr    = r_wr_perr;
  assign bus.line_reset = r_line_reset;
  assign bus.proto_err  = r_proto_err;

endmodule

// File: tb/tb_swd_target.sv
// Bench for swd_target: a host model drives SWD bit cycles; upstream pulses are
// checked by a queue-based scoreboard, wire-level target bits inline by the host.
module tb_swd_target;
  import swd_pkg::*;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       swclk_i = 1'b0;
  logic       host_val = 1'b0;
  logic       swdio_i;
  logic       swdio_o;
  logic       swdio_oe;
  logic [1:0] turnaround = 2'd0;

  int checks = 0;
  int failures = 0;
  logic s_o, s_oe;

  logic [3:0]  q_req[$];
  logic [32:0] q_wr[$];
  logic        q_lr[$];
  logic        q_pe[$];

  swd_target_if bus();

  assign swdio_i = swdio_oe ? swdio_o : host_val;

  swd_target #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .swclk_i    (swclk_i),
    .swdio_i    (swdio_i),
    .swdio_o    (swdio_o),
    .swdio_oe   (swdio_oe),
    .turnaround (turnaround),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    failures++;
    $display("FAIL %s pulse seen with nothing expected t=%0t", nm, $time);
  endtask

  // Scoreboard monitor: every upstream pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_valid) begin
        if (q_req.size() == 0) unexpected("req_valid");
        else chk("req_fields", {bus.req_apndp, bus.req_rnw, bus.req_addr}, q_req.pop_front());
      end
      if (bus.wr_valid) begin
        if (q_wr.size() == 0) unexpected("wr_valid");
        else chk("wr_data_perr", {bus.wr_perr, bus.wr_data}, q_wr.pop_front());
      end
      if (bus.line_reset) begin
        if (q_lr.size() == 0) unexpected("line_reset");
        else chk("line_reset", bus.line_reset, q_lr.pop_front());
      end
      if (bus.proto_err) begin
        if (q_pe.size() == 0) unexpected("proto_err");
        else chk("proto_err", bus.proto_err, q_pe.pop_front());
      end
    end
  end

  // One SWCLK period; s_o/s_oe capture what the target drove after the previous rise
  task automatic cyc(input logic v);
    swclk_i  = 1'b0;
    host_val = v;
    repeat (HALF) @(negedge clk);
    s_o  = swdio_o;
    s_oe = swdio_oe;
    swclk_i = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_header(input logic apndp, input logic rnw, input logic [1:0] addr,
                             input logic bad);
    logic       par;
    logic [7:0] hb;
    par = apndp ^ rnw ^ addr[0] ^ addr[1] ^ bad;
    hb  = {1'b1, 1'b0, par, addr[1], addr[0], rnw, apndp, 1'b1};
    if (bad) q_pe.push_back(1'b1);
    else     q_req.push_back({apndp, rnw, addr});
    for (int i = 0; i < 8; i++) begin
      cyc(hb[i]);
      chk("hdr_oe", s_oe, 1'b0);
    end
  endtask

  task automatic txn(input logic apndp, input logic rnw, input logic [1:0] addr,
                     input int tlen, input logic rv, input logic [2:0] ack,
                     input logic [31:0] data, input logic flip, input int abort_bit);
    logic [2:0] exp_ack;
    exp_ack = rv ? ack : ACK_WAIT;
    turnaround      = 2'(tlen - 1);
    bus.resp_valid  = rv;
    bus.resp_ack    = ack;
    bus.resp_rdata  = data;
    send_header(apndp, rnw, addr, 1'b0);
    for (int i = 0; i < tlen; i++) begin
      cyc(1'b1);
      chk("trn1_oe", s_oe, 1'b0);
    end
    bus.resp_valid = 1'b0;
    bus.resp_rdata = $urandom();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      chk("ack_bit", {s_oe, s_o}, {1'b1, exp_ack[i]});
    end
    if (exp_ack == ACK_OK && rnw) begin
      for (int i = 0; i < 32; i++) begin
        cyc(1'b0);
        chk("rdata_bit", {s_oe, s_o}, {1'b1, data[i]});
        if (i == abort_bit) begin
          swclk_i  = 1'b0;
          host_val = 1'b0;
          rst      = 1'b1;
          @(negedge clk);
          chk("rst_drops_oe", swdio_oe, 1'b0);
          repeat (3) @(negedge clk);
          rst = 1'b0;
          repeat (3) cyc(1'b0);
          return;
        end
      end
      cyc(1'b0);
      chk("rdata_parity", {s_oe, s_o}, {1'b1, ^data});
      cyc(1'b0);
      chk("read_release", s_oe, 1'b0);
    end else if (exp_ack == ACK_OK) begin
      q_wr.push_back({flip, data});
      cyc(1'b0);
      chk("write_release", s_oe, 1'b0);
      for (int i = 1; i < tlen; i++) cyc(1'b0);
      for (int i = 0; i < 32; i++) cyc(data[i]);
      cyc((^data) ^ flip);
    end else begin
      cyc(1'b0);
      chk("nonok_release", s_oe, 1'b0);
    end
    repeat (2) cyc(1'b0);
    chk("idle_oe", swdio_oe, 1'b0);
  endtask

  initial begin
    int grp;
    bus.resp_valid = 1'b0;
    bus.resp_ack   = 3'b000;
    bus.resp_rdata = 32'h0;
    repeat (4) @(negedge clk);
    chk("rst_pins", {swdio_oe, swdio_o}, 2'b00);
    chk("rst_req", {bus.req_valid, bus.req_apndp, bus.req_rnw, bus.req_addr}, 5'b0);
    chk("rst_wr", {bus.wr_valid, bus.wr_perr, bus.wr_data}, 34'b0);
    chk("rst_pulses", {bus.line_reset, bus.proto_err}, 2'b00);
    rst = 1'b0;
    repeat (3) cyc(1'b0);

    txn(1'b1, 1'b1, 2'b01, 1, 1'b1, ACK_OK, 32'hDEADBEEF, 1'b0, -1);
    txn(1'b0, 1'b0, 2'b00, 2, 1'b1, ACK_OK, 32'h12345678, 1'b0, -1);
    txn(1'b0, 1'b0, 2'b00, 2, 1'b1, ACK_OK, 32'h12345678, 1'b1, -1);
    txn(1'b1, 1'b1, 2'b10, 3, 1'b0, ACK_OK, 32'hCAFEF00D, 1'b0, -1);
    txn(1'b0, 1'b1, 2'b11, 4, 1'b1, ACK_FAULT, 32'h0, 1'b0, -1);

    send_header(1'b0, 1'b1, 2'b11, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0);
      chk("badhdr_oe", s_oe, 1'b0);
    end

    // 52 ones: every 8 ones form a header with stop=1, the 50th one is a line reset
    grp = 0;
    for (int k = 1; k <= 52; k++) begin
      if (k < 50) begin
        grp++;
        if (grp == 8) begin
          q_pe.push_back(1'b1);
          grp = 0;
        end
      end else if (k == 50) begin
        q_lr.push_back(1'b1);
      end
    end
    for (int k = 1; k <= 52; k++) cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    txn(1'b0, 1'b1, 2'b10, 2, 1'b1, ACK_OK, 32'hA5A50F0F, 1'b0, -1);

    txn(1'b1, 1'b1, 2'b00, 2, 1'b1, ACK_OK, 32'h89ABCDEF, 1'b0, 10);
    txn(1'b1, 1'b0, 2'b11, 1, 1'b1, ACK_OK, 32'h0F1E2D3C, 1'b0, -1);

    for (int n = 0; n < 12; n++) begin
      logic [2:0] a;
      case ($urandom_range(0, 3))
        0, 1:    a = ACK_OK;
        2:       a = ACK_WAIT;
        default: a = ACK_FAULT;
      endcase
      if ($urandom_range(0, 5) == 0) begin
        send_header(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'b1);
        repeat (2) cyc(1'b0);
      end else begin
        txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom_range(1, 4), $urandom_range(0, 4) != 0, a, $urandom(),
            1'($urandom_range(0, 1)), -1);
      end
    end

    repeat (10) @(negedge clk);
    chk("req_left", q_req.size(), 0);
    chk("wr_left", q_wr.size(), 0);
    chk("lr_left", q_lr.size(), 0);
    chk("pe_left", q_pe.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
